// File: rtl/pwm_pair_monitor.sv
// Per-frame monitor for a complementary PWM pair: high times, period, minimum dead time,
// shoot-through and dead-time faults. Define PWM_MON_SYNC_EN to add 2-flop input synchronizers.
module pwm_pair_monitor #(
  parameter int unsigned W        = 11,
  parameter int unsigned MIN_DEAD = 60
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         synch,
  input  logic         pwm_a,
  input  logic         pwm_b,
  input  logic         clr_err,
  output logic [W-1:0] high_a,
  output logic [W-1:0] high_b,
  output logic [W:0]   period,
  output logic [W-1:0] dead_min,
  output logic         meas_vld,
  output logic         timeout,
  output logic         ovlp_err,
  output logic         dead_err
);

  localparam logic [W-1:0] CNT_MAX  = '1;
  localparam logic [W:0]   PER_MAX  = '1;
  localparam logic [W-1:0] DEAD_LIM = W'(MIN_DEAD);

  typedef enum logic {ARMED, MEASURE} state_t;

  logic synch_s, a_s, b_s;

`ifdef PWM_MON_SYNC_EN
  logic [1:0] synch_ff, a_ff, b_ff;

  always_ff @(posedge clk) begin
    if (rst) begin
      synch_ff <= '0;
      a_ff     <= '0;
      b_ff     <= '0;
    end else begin
      synch_ff <= {synch_ff[0], synch};
      a_ff     <= {a_ff[0], pwm_a};
      b_ff     <= {b_ff[0], pwm_b};
    end
  end

  assign synch_s = synch_ff[1];
  assign a_s     = a_ff[1];
  assign b_s     = b_ff[1];
`else
  assign synch_s = synch;
  assign a_s     = pwm_a;
  assign b_s     = pwm_b;
`endif

  state_t       state;
  logic         a_q, b_q;
  logic [W:0]   per_cnt;
  logic [W-1:0] ha_cnt, hb_cnt;
  logic [W-1:0] gap_cnt;
  logic [W-1:0] min_cur;
  logic         fell;

  logic         rise, fall, gap_hit, ovlp_now, dead_set;
  logic [W-1:0] ha_inc, hb_inc, gap_nxt, min_upd, min_start;

  always_comb begin
    rise      = (a_s & ~a_q) | (b_s & ~b_q);
    fall      = (~a_s & a_q) | (~b_s & b_q);
    gap_hit   = rise & fell;
    ovlp_now  = a_s & b_s;
    ha_inc    = (a_s && ha_cnt != CNT_MAX) ? ha_cnt + W'(1) : ha_cnt;
    hb_inc    = (b_s && hb_cnt != CNT_MAX) ? hb_cnt + W'(1) : hb_cnt;
    gap_nxt   = '0;
    if (!a_s && !b_s)
      gap_nxt = (gap_cnt == CNT_MAX) ? gap_cnt : gap_cnt + W'(1);
    min_upd   = (gap_hit && gap_cnt < min_cur) ? gap_cnt : min_cur;
    // A gap closing in the synch cycle belongs to the frame that starts there.
    min_start = gap_hit ? gap_cnt : '1;
    dead_set  = en && (state == MEASURE) && synch_s && (min_cur < DEAD_LIM);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ARMED;
      a_q      <= 1'b0;
      b_q      <= 1'b0;
      per_cnt  <= '0;
      ha_cnt   <= '0;
      hb_cnt   <= '0;
      gap_cnt  <= '0;
      min_cur  <= '1;
      fell     <= 1'b0;
      high_a   <= '0;
      high_b   <= '0;
      period   <= '0;
      dead_min <= '1;
      meas_vld <= 1'b0;
      timeout  <= 1'b0;
      ovlp_err <= 1'b0;
      dead_err <= 1'b0;
    end else begin
      meas_vld <= 1'b0;
      timeout  <= 1'b0;
      a_q      <= a_s;
      b_q      <= b_s;
      ovlp_err <= ovlp_now | (ovlp_err & ~clr_err);
      dead_err <= dead_set | (dead_err & ~clr_err);

      if (!en) begin
        state   <= ARMED;
        per_cnt <= '0;
        ha_cnt  <= '0;
        hb_cnt  <= '0;
        gap_cnt <= '0;
        min_cur <= '1;
        fell    <= 1'b0;
      end else begin
        gap_cnt <= gap_nxt;
        if (fall)
          fell <= 1'b1;
        else if (rise)
          fell <= 1'b0;

        case (state)
          ARMED: begin
            if (synch_s) begin
              state   <= MEASURE;
              per_cnt <= (W+1)'(1);
              ha_cnt  <= W'(a_s);
              hb_cnt  <= W'(b_s);
              min_cur <= min_start;
            end
          end
          MEASURE: begin
            if (synch_s) begin
              high_a   <= ha_cnt;
              high_b   <= hb_cnt;
              period   <= per_cnt;
              dead_min <= min_cur;
              meas_vld <= 1'b1;
              per_cnt  <= (W+1)'(1);
              ha_cnt   <= W'(a_s);
              hb_cnt   <= W'(b_s);
              min_cur  <= min_start;
            end else if (per_cnt == PER_MAX) begin
              state   <= ARMED;
              timeout <= 1'b1;
              per_cnt <= '0;
              ha_cnt  <= '0;
              hb_cnt  <= '0;
              min_cur <= '1;
            end else begin
              per_cnt <= per_cnt + (W+1)'(1);
              ha_cnt  <= ha_inc;
              hb_cnt  <= hb_inc;
              min_cur <= min_upd;
            end
          end
          default: state <= ARMED;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pwm_pair_monitor.sv
// Directed bench for pwm_pair_monitor (default build, inputs used without synchronizers).
module tb_pwm_pair_monitor;

  logic        clk = 1'b0;
  logic        rst, en, synch, pwm_a, pwm_b, clr_err;
  logic [10:0] high_a, high_b, dead_min;
  logic [11:0] period;
  logic        meas_vld, timeout, ovlp_err, dead_err;

  int tests = 0;
  int fails = 0;
  int vf, vr, tc;
  int to_first, to_n, vld_n;

  always #5 clk = ~clk;

  pwm_pair_monitor #(.W(11), .MIN_DEAD(60)) dut (
    .clk(clk), .rst(rst), .en(en), .synch(synch), .pwm_a(pwm_a), .pwm_b(pwm_b),
    .clr_err(clr_err), .high_a(high_a), .high_b(high_b), .period(period),
    .dead_min(dead_min), .meas_vld(meas_vld), .timeout(timeout),
    .ovlp_err(ovlp_err), .dead_err(dead_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // One frame: synch in cycle 0, pwm_a high in [a0,a0+alen), pwm_b high in [b0,b0+blen).
  task automatic run_frame(input int len, input int a0, input int alen, input int b0,
                           input int blen, input int clr_at, input int en_off_at,
                           output int vld_first, output int vld_rest, output int to_cnt);
    vld_first = 0;
    vld_rest  = 0;
    to_cnt    = 0;
    for (int i = 0; i < len; i++) begin
      synch   = (i == 0);
      pwm_a   = (i >= a0) && (i < a0 + alen);
      pwm_b   = (i >= b0) && (i < b0 + blen);
      clr_err = (i == clr_at);
      en      = !((en_off_at >= 0) && (i >= en_off_at) && (i < en_off_at + 10));
      tick();
      if (i == 0) vld_first = int'(meas_vld);
      else        vld_rest += int'(meas_vld);
      to_cnt += int'(timeout);
    end
    synch   = 1'b0;
    clr_err = 1'b0;
    en      = 1'b1;
  endtask

  task automatic nominal(input int clr_at);
    run_frame(2048, 0, 400, 464, 1520, clr_at, -1, vf, vr, tc);
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; synch = 1'b0; pwm_a = 1'b0; pwm_b = 1'b0; clr_err = 1'b0;
    repeat (3) tick();
    chk("rst_high_a", high_a, 0);
    chk("rst_high_b", high_b, 0);
    chk("rst_period", period, 0);
    chk("rst_dead_min", dead_min, 2047);
    chk("rst_flags", {meas_vld, timeout, ovlp_err, dead_err}, 0);

    rst = 1'b0; en = 1'b1;
    repeat (5) tick();

    // Nominal frames
    nominal(-1);
    chk("arm_no_vld", vf + vr, 0);
    nominal(-1);
    chk("nom_vld_first", vf, 1);
    chk("nom_vld_rest", vr, 0);
    chk("nom_high_a", high_a, 400);
    chk("nom_high_b", high_b, 1520);
    chk("nom_period", period, 2048);
    chk("nom_dead_min", dead_min, 64);
    chk("nom_errs", {ovlp_err, dead_err}, 0);

    // Back-to-back synch
    run_frame(1, 0, 1, 0, 0, -1, -1, vf, vr, tc);
    chk("b2b0_vld", vf, 1);
    run_frame(1, 0, 0, 0, 0, -1, -1, vf, vr, tc);
    chk("b2b1_vld", vf, 1);
    chk("b2b1_period", period, 1);
    chk("b2b1_high_a", high_a, 1);
    chk("b2b1_high_b", high_b, 0);
    nominal(-1);
    chk("b2b2_vld", vf, 1);
    chk("b2b2_period", period, 1);
    chk("b2b2_high_a", high_a, 0);

    // Shoot-through: pwm_b rises 3 cycles before pwm_a falls
    run_frame(2048, 0, 400, 397, 1587, -1, -1, vf, vr, tc);
    chk("ovlp_set", ovlp_err, 1);
    nominal(-1);
    chk("ovlp_frame_high_b", high_b, 1587);
    chk("ovlp_sticky", ovlp_err, 1);
    nominal(1000);
    chk("ovlp_cleared", ovlp_err, 0);
    run_frame(2048, 0, 400, 399, 1585, 399, -1, vf, vr, tc);
    chk("ovlp_set_wins", ovlp_err, 1);
    nominal(10);
    chk("ovlp_cleared2", ovlp_err, 0);
    chk("ovlp_no_dead_err", dead_err, 0);

    // Short dead time: 64-cycle gap at frame start, 20-cycle gap mid-frame
    run_frame(2048, 0, 400, 420, 1564, -1, -1, vf, vr, tc);
    nominal(-1);
    chk("short_dead_min", dead_min, 20);
    chk("short_dead_err", dead_err, 1);
    chk("short_high_b", high_b, 1564);
    nominal(-1);
    chk("after_short_dead_min", dead_min, 64);
    chk("dead_err_sticky", dead_err, 1);

    // Lost synch: frame above started at index 0; timeout expected after cycle 4095
    to_first = -1; to_n = 0; vld_n = 0;
    for (int k = 2048; k < 4200; k++) begin
      synch = 1'b0; pwm_a = 1'b0; pwm_b = 1'b0; clr_err = (k == 2048);
      tick();
      if (timeout) begin
        to_n++;
        if (to_first < 0) to_first = k;
      end
      vld_n += int'(meas_vld);
    end
    clr_err = 1'b0;
    chk("dead_err_cleared", dead_err, 0);
    chk("timeout_cycle", to_first, 4095);
    chk("timeout_count", to_n, 1);
    chk("timeout_no_vld", vld_n, 0);
    nominal(-1);
    chk("rearm_no_vld", vf, 0);
    nominal(-1);
    chk("rearm_vld", vf, 1);
    chk("rearm_period", period, 2048);

    // Frame of 4095 cycles: synch coincides with the timeout point
    run_frame(4095, 0, 400, 464, 1520, -1, -1, vf, vr, tc);
    chk("long_no_timeout", tc, 0);
    nominal(-1);
    chk("long_vld", vf, 1);
    chk("long_timeout_edge", tc, 0);
    chk("long_period", period, 4095);

    // Saturation: pwm_a high for a 3000-cycle frame
    run_frame(3000, 0, 3000, 0, 0, -1, -1, vf, vr, tc);
    nominal(-1);
    chk("sat_high_a", high_a, 2047);
    chk("sat_high_b", high_b, 0);
    chk("sat_period", period, 3000);

    // en dropped mid-frame: frame discarded, next synch only re-arms
    run_frame(1500, 0, 400, 464, 900, -1, 1000, vf, vr, tc);
    chk("en_prev_vld", vf, 1);
    nominal(-1);
    chk("en_drop_no_vld", vf + vr, 0);
    chk("en_drop_period", period, 2048);
    chk("en_drop_high_a", high_a, 400);

    // Reset mid-frame
    synch = 1'b1; tick();
    synch = 1'b0; pwm_a = 1'b1; pwm_b = 1'b1; tick();
    pwm_a = 1'b0; pwm_b = 1'b0;
    chk("pre_rst_ovlp", ovlp_err, 1);
    repeat (20) tick();
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    chk("mid_rst_high_a", high_a, 0);
    chk("mid_rst_high_b", high_b, 0);
    chk("mid_rst_period", period, 0);
    chk("mid_rst_dead_min", dead_min, 2047);
    chk("mid_rst_flags", {meas_vld, timeout, ovlp_err, dead_err}, 0);
    to_n = 0; vld_n = 0;
    for (int k = 0; k < 5000; k++) begin
      tick();
      to_n  += int'(timeout);
      vld_n += int'(meas_vld);
    end
    chk("post_rst_quiet", to_n + vld_n, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pwm_pair_monitor.md
# pwm_pair_monitor

Measures a complementary PWM pair, such as the high-side/low-side gate drives of one motor bridge leg, over each PWM frame. Frames are delimited by the one-cycle frame-start pulse that the PWM generator emits once per counter wrap. Each frame, the block reports the high time of each output, the frame period and the smallest dead time observed. It also flags shoot-through (both outputs high) and insufficient dead time. It sits next to the motor-drive PWM in the Segway datapath and feeds the self-test and fault logic.

## Interface
- W, 11: PWM counter width; nominal frame length 2^W cycles
- MIN_DEAD, 60: minimum legal dead time, in cycles
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- en  in  1  monitor enable; low forces state ARMED and clears all working counters
- synch  in  1  frame-start pulse, one cycle wide
- pwm_a  in  1  high-side PWM input
- pwm_b  in  1  low-side (complementary) PWM input
- clr_err  in  1  clears the sticky error flags
- high_a  out  W  high cycles of pwm_a in the last frame; saturates at 2^W-1
- high_b  out  W  high cycles of pwm_b in the last frame; saturates at 2^W-1
- period  out  W+1  cycles in the last frame
- dead_min  out  W  smallest dead gap in the last frame; all-ones if no gap was measured
- meas_vld  out  1  one-cycle pulse: the result outputs were updated
- timeout  out  1  one-cycle pulse: no synch arrived within 2^(W+1)-1 cycles
- ovlp_err  out  1  sticky: pwm_a and pwm_b were both high in some cycle
- dead_err  out  1  sticky: a reported dead_min was below MIN_DEAD

## Operation
- Input stage: synch, pwm_a and pwm_b pass through an input stage (see Configuration). All logic below uses the staged signals.
- State machine, two states:
  - ARMED: the reset state. Moves to MEASURE on synch while en=1.
  - MEASURE: counts until the next synch.
    - On synch: report the frame, clear counters, stay in MEASURE. The same synch cycle is cycle 0 of the new frame.
    - On timeout: go to ARMED and pulse timeout. meas_vld does not pulse.
- Frame counters, cleared at synch:
  - per_cnt: W+1 bits, increments every MEASURE cycle, starting at 1 in the synch cycle.
  - ha_cnt and hb_cnt: count cycles in which pwm_a or pwm_b is high, saturating at 2^W-1.
- Report: period, high_a and high_b take the counter values accumulated before the terminating synch cycle. That cycle itself is not included.
- Dead-time tracking:
  - gap_cnt: W bits, saturating. Increments while both inputs are low; cleared when either input is high.
  - fell flag: set on any falling edge of pwm_a or pwm_b; cleared on any rising edge.
  - On a rising edge of either input with fell=1, min_cur = min(min_cur, gap_cnt).
  - gap_cnt and fell are not cleared at synch, so a gap that spans the frame boundary counts toward the frame in which it ends.
  - min_cur resets to all-ones at each synch, after its value is reported.
- Errors:
  - ovlp_err sets in any cycle with pwm_a=pwm_b=1, in either state.
  - dead_err sets at a report when dead_min < MIN_DEAD.
  - clr_err clears both flags. If clr_err and a new error occur in the same cycle, the set wins.
- Timeout: fires when per_cnt reaches 2^(W+1)-1 in MEASURE.
- Changing en: when en falls mid-frame, the frame is discarded and no report is made.

## Timing
- Reset values: all outputs 0, except dead_min all-ones. State is ARMED; all counters and flags are 0.
- Report latency: results are registered at the synch edge. meas_vld is high in the cycle after the staged synch, with the new values valid in that same cycle. Results hold until the next report.
- Error latency: ovlp_err is high in the cycle after the staged overlap cycle.
- Back-to-back synch: two synch pulses one cycle apart report period=1 and high counts of 0 or 1. No pulse is lost.
- Simultaneous synch and timeout: synch wins and the frame reports normally.
- Reset mid-frame: the frame is discarded; no meas_vld or timeout pulse is produced.

## Configuration
- PWM_MON_SYNC_EN
  - Defined: a 2-flop synchronizer on each of synch, pwm_a and pwm_b (for pins arriving off-chip). All latencies grow by 2 cycles.
  - Undefined: inputs are used directly (same-clock on-chip source). This is the latency stated above.

## Test plan
- Nominal frame: synch every 2048 cycles; pwm_a high 400 cycles; 64-cycle gap; pwm_b high 1520; 64-cycle gap → high_a=400, high_b=1520, period=2048, dead_min=64, meas_vld exactly one cycle after the second synch, no errors.
- Shoot-through: pwm_b rises 3 cycles before pwm_a falls → ovlp_err=1, and it holds through later clean frames. A clr_err pulse clears it; clr_err coinciding with another overlap leaves it set.
- Short dead time: gaps of 64 and then 20 → dead_min=20, dead_err=1. In a later frame with 64-cycle gaps, dead_min=64 and dead_err stays 1 until clr_err.
- Lost synch: one synch, then none → timeout pulses one cycle at per_cnt=4095, state returns to ARMED, no meas_vld. The next synch restarts measurement.
- Saturation and edge cases: pwm_a held high for a 3000-cycle frame → high_a=2047, period=3000. With en dropped mid-frame, no report is produced.
- Reset: rst asserted mid-frame → all outputs return to reset values. With PWM_MON_SYNC_EN defined, the nominal frame reports identical values with meas_vld 2 cycles later.
